// File: rtl/md_sched.sv
// md_sched: multi-cycle multiply/divide sequencer owning HI/LO (mult/div/mthi/mtlo).
// Optional MD_MADD_EN adds madd/msub accumulate ops on md_op 110/111.
`default_nettype none

module md_sched #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [5:0] MUL_LD = 6'(MUL_CYCLES);
  localparam logic [5:0] DIV_LD = 6'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic [63:0] prod_s, prod_u, res;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] div_a, div_b, uq, ur, q_fix, r_fix;

  // Result datapath works only on the latched operands.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Single unsigned divider on magnitudes; signs restored afterwards.
    div_signed = ~op_q[0];
    a_neg      = div_signed & a_q[31];
    b_neg      = div_signed & b_q[31];
    div_a      = a_neg ? (~a_q + 32'd1) : a_q;
    div_b      = b_neg ? (~b_q + 32'd1) : b_q;
    if (b_q == 32'd0) begin
      uq = 32'hFFFF_FFFF;
      ur = 32'd0;
    end else begin
      uq = div_a / div_b;
      ur = div_a % div_b;
    end
    q_fix = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    r_fix = a_neg ? (~ur + 32'd1) : ur;

    case (op_q)
      3'b000:  res = prod_s;
      3'b001:  res = prod_u;
      3'b010,
      3'b011:  res = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {r_fix, q_fix};
`ifdef MD_MADD_EN
      3'b110:  res = {hi_q, lo_q} + prod_s;
      3'b111:  res = {hi_q, lo_q} - prod_s;
`endif
      default: res = prod_s;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              state_d = S_RUN;
              cnt_d   = md_op[1] ? DIV_LD : MUL_LD;
              op_d    = md_op;
              a_d     = A;
              b_d     = B;
            end
            3'b100: hi_d = A;
            3'b101: lo_d = A;
`ifdef MD_MADD_EN
            3'b110, 3'b111: begin
              state_d = S_RUN;
              cnt_d   = MUL_LD;
              op_d    = md_op;
              a_d     = A;
              b_d     = B;
            end
`endif
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cnt_q == 6'd1) begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
          hi_d    = res[63:32];
          lo_d    = res[31:0];
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed vector table, corner sequences, random ops vs. model.
`default_nettype none

module tb_md_sched;

  localparam int MUL_L = 5;
  localparam int DIV_L = 10;

  logic        clk, reset, start;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] HI, LO;

  md_sched #(.MUL_CYCLES(MUL_L), .DIV_CYCLES(DIV_L)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural model: returns busy latency (0 = immediate write, -1 = no-op).
  function automatic int model_step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); {m_hi, m_lo} = p; return MUL_L; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; return MUL_L; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a;
        end else if (op == 3'd2) begin
          q = sa / sb; r = sa - q * sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
        return DIV_L;
      end
      3'd4: begin m_hi = a; return 0; end
      3'd5: begin m_lo = a; return 0; end
      default: begin
`ifdef MD_MADD_EN
        p = 64'(sa * sb);
        if (op == 3'd6) {m_hi, m_lo} = {m_hi, m_lo} + p;
        else            {m_hi, m_lo} = {m_hi, m_lo} - p;
        return MUL_L;
`else
        return -1;
`endif
      end
    endcase
  endfunction

  // Called at a negedge; returns at the done negedge (multi-cycle) or the negedge after accept.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int inj);
    int lat, busy_cyc;
    bit seen;
    lat = model_step(op, a, b);
    start = 1'b1; md_op = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; md_op = 3'($urandom);
    if (lat <= 0) begin
      @(negedge clk);
      chk("imm_busy", 64'(busy), 64'd0);
      chk("imm_done", 64'(done), 64'd0);
    end else begin
      busy_cyc = 0; seen = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (done) seen = 1;
        else begin
          if (busy) busy_cyc++;
          if (c + 1 == inj) begin
            start = 1'b1; md_op = 3'b011; A = $urandom; B = 32'd3;
          end
        end
      end
      start = 1'b0;
      chk("done_seen", 64'(seen), 64'd1);
      chk("busy_len", 64'(busy_cyc), 64'(lat));
      chk("busy_at_done", 64'(busy), 64'd0);
    end
    chk("HI", 64'(HI), 64'(m_hi));
    chk("LO", 64'(LO), 64'(m_lo));
  endtask

  task automatic idle_chk();
    @(negedge clk);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int dones;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{3'd3, 32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[4] = '{3'd0, 32'd6,         32'd7,        32'h0000_0000, 32'h0000_002A};
    vecs[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{3'd2, 32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF};
    vecs[7] = '{3'd2, 32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2};

    reset = 1'b0; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_HI", 64'(HI), 64'd0);
    chk("rst_LO", 64'(LO), 64'd0);
    reset = 1'b1;

    // Back-to-back: each op starts in the done cycle of the previous one.
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0);
      chk("vec_HI", 64'(HI), 64'(vecs[i].hi));
      chk("vec_LO", 64'(LO), 64'(vecs[i].lo));
    end
    idle_chk();

    do_op(3'd4, 32'h1234_5678, 32'd0, 0);
    chk("mthi_HI", 64'(HI), 64'h1234_5678);
    chk("mthi_LO", 64'(LO), 64'hFFFF_FFF2);
    do_op(3'd5, 32'hCAFE_0001, 32'd0, 0);
    chk("mtlo_HI", 64'(HI), 64'h1234_5678);

    // Reserved op (no-op when accumulate is not built), then start-while-busy.
`ifndef MD_MADD_EN
    do_op(3'd6, 32'd9, 32'd9, 0);
    chk("rsv_HI", 64'(HI), 64'h1234_5678);
    chk("rsv_LO", 64'(LO), 64'hCAFE_0001);
`endif
    do_op(3'd0, 32'd1000, 32'hFFFF_FFFF, 2);
    chk("busy_start_LO", 64'(LO), 64'hFFFF_FC18);
    idle_chk();

    // Asynchronous reset in the middle of a divu.
    start = 1'b1; md_op = 3'd3; A = 32'd77; B = 32'd5;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0; #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_HI", 64'(HI), 64'd0);
    chk("mid_rst_LO", 64'(LO), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    #2 reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("no_done_after_rst", 64'(dones), 64'd0);
    chk("no_commit_after_rst", 64'({HI, LO}), 64'd0);
    do_op(3'd0, 32'd12, 32'hFFFF_FFFD, 0);

`ifdef MD_MADD_EN
    do_op(3'd4, 32'd0, 32'd0, 0);
    do_op(3'd5, 32'd10, 32'd0, 0);
    do_op(3'd6, 32'd2, 32'd3, 0);
    chk("madd_LO", 64'(LO), 64'd16);
    do_op(3'd7, 32'd1, 32'd20, 0);
    chk("msub_HILO", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFC);
`endif

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = {28'd0, 4'($urandom)};
      do_op(rop, ra, rb, 0);
      if ($urandom_range(0, 1) == 1) idle_chk();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
